t_flip_flop_bank: RTL and testbench

//   Parametrised bank of WIDTH T flip-flops with true/complement outputs.

---
 rtl/t_flip_flop_bank.sv | 69 ++++++
 tb/tb_t_flip_flop_bank.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/t_flip_flop_bank.sv
// rtl/t_flip_flop_bank.sv - bank of T flip-flops with independent/cascade modes; optional TFF_EDGE_DETECT_EN
module t_flip_flop_bank #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             cascade,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             wrap
);

  logic [WIDTH-1:0] t_eff;
  logic [WIDTH-1:0] tog;
  logic [WIDTH-1:0] q_next;
  logic             wrap_next;
  logic             carry;

`ifdef TFF_EDGE_DETECT_EN
  logic [WIDTH-1:0] t_d;

  // Tracks t on every non-reset cycle so load/hold cycles still age the edge history.
  always_ff @(posedge clk) begin
    if (reset) t_d <= '0;
    else       t_d <= t;
  end

  assign t_eff = t & ~t_d;
`else
  assign t_eff = t;
`endif

  // Ripple the count enable up through the bank: bit i toggles when all lower bits are 1.
  always_comb begin
    tog   = '0;
    carry = t_eff[0];
    for (int i = 0; i < WIDTH; i++) begin
      tog[i] = carry;
      carry  = carry & q[i];
    end
  end

  assign q_next    = cascade ? (q ^ tog) : (q ^ t_eff);
  assign wrap_next = cascade & t_eff[0] & (&q);

  always_ff @(posedge clk) begin
    if (reset) begin
      q     <= RESET_VAL;
      q_bar <= ~RESET_VAL;
      wrap  <= 1'b0;
    end else if (load) begin
      q     <= load_val;
      q_bar <= ~load_val;
      wrap  <= 1'b0;
    end else if (en) begin
      q     <= q_next;
      q_bar <= ~q_next;
      wrap  <= wrap_next;
    end else begin
      wrap  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_t_flip_flop_bank.sv
// tb/tb_t_flip_flop_bank.sv - directed + random checks of t_flip_flop_bank against a counter/XOR model
module tb_t_flip_flop_bank;

  logic       clk = 1'b0;
  logic       reset, en, load, cascade;
  logic [3:0] load_val, t;
  logic [3:0] q, q_bar, q_rv, q_bar_rv;
  logic       wrap, wrap_rv;

  int checks = 0;
  int errors = 0;

  // Reference state: value as an integer, previous t for edge mode.
  int         m_q;
  logic       m_wrap;
  logic [3:0] m_td;

  always #5 clk = ~clk;

  t_flip_flop_bank #(.WIDTH(4), .RESET_VAL(4'b0000)) dut (
    .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
    .cascade(cascade), .t(t), .q(q), .q_bar(q_bar), .wrap(wrap)
  );

  t_flip_flop_bank #(.WIDTH(4), .RESET_VAL(4'b1010)) dut_rv (
    .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
    .cascade(cascade), .t(t), .q(q_rv), .q_bar(q_bar_rv), .wrap(wrap_rv)
  );

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic [3:0] teff;
`ifdef TFF_EDGE_DETECT_EN
    teff = t & ~m_td;
`else
    teff = t;
`endif
    if (reset) begin
      m_q = 0; m_wrap = 1'b0; m_td = 4'b0000;
    end else begin
      if (load) begin
        m_q = int'(load_val); m_wrap = 1'b0;
      end else if (en && cascade) begin
        m_wrap = teff[0] && (m_q == 15);
        if (teff[0]) m_q = (m_q + 1) % 16;
      end else if (en) begin
        m_q = m_q ^ int'(teff); m_wrap = 1'b0;
      end else begin
        m_wrap = 1'b0;
      end
      m_td = t;
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check({tag, ".q"},     q,     m_q[3:0]);
    check({tag, ".q_bar"}, q_bar, ~m_q[3:0]);
    check({tag, ".wrap"},  {3'b000, wrap}, {3'b000, m_wrap});
  endtask

  task automatic drive(input logic r, input logic l, input logic [3:0] lv,
                       input logic e, input logic c, input logic [3:0] tv);
    reset = r; load = l; load_val = lv; en = e; cascade = c; t = tv;
  endtask

  initial begin
    m_q = 0; m_wrap = 1'b0; m_td = 4'b0000;
    drive(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0);

    // Reset held two cycles; the second instance shows the non-zero reset value.
    cycle("rst0");
    cycle("rst1");
    check("rv.q", q_rv, 4'b1010);
    check("rv.q_bar", q_bar_rv, 4'b0101);
    check("rv.wrap", {3'b000, wrap_rv}, 4'b0000);

    // Independent toggle, then hold with en=0.
    drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'b0101);
    cycle("ind");
    check("ind.const", q, 4'b0101);
    drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'b1111);
    cycle("hold");
    check("hold.const", q, 4'b0101);

    // Cascade count from zero through roll-over.
    drive(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0);
    cycle("ld0");
    drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'b0001);
    for (int k = 0; k < 17; k++) cycle("cnt");

    // Load wins over enable, then count 1110 -> 1111 -> 0000 with wrap.
    drive(1'b0, 1'b1, 4'b1110, 1'b1, 1'b0, 4'b1111);
    cycle("ldwin");
    check("ldwin.const", q, 4'b1110);
    drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'b0001);
    cycle("ld+1");
    drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'b0000);
    cycle("gap");
    drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'b0001);
    cycle("ld+2");
    check("roll.q", q, 4'b0000);
    check("roll.wrap", {3'b000, wrap}, 4'b0001);

    // Reset beats load mid-count.
    drive(1'b0, 1'b1, 4'b0110, 1'b0, 1'b0, 4'h0);
    cycle("ld6");
    drive(1'b1, 1'b1, 4'b1111, 1'b1, 1'b1, 4'b0001);
    cycle("rstwin");
    check("rstwin.const", q, 4'b0000);

    // t[2] held high five enabled cycles.
    drive(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'b0100);
    for (int k = 0; k < 5; k++) cycle("hold_t2");
`ifdef TFF_EDGE_DETECT_EN
    check("t2.edge", q, 4'b0100);
`else
    check("t2.level", q, 4'b0100);
`endif

    // Randomized traffic, including mode changes, loads and occasional resets.
    for (int k = 0; k < 300; k++) begin
      drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 9) == 0), 4'($urandom),
            ($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom));
      cycle("rand");
      check("rand.inv", q_bar, ~q);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
